// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory request scheduler.
package mem_pkg;

    localparam int unsigned AW_DEF    = 10;
    localparam int unsigned DW_DEF    = 8;
    localparam int unsigned DEPTH_DEF = 4;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RD_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO for mem_req_sched; head entry is visible while not empty.
module mem_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/mem_req_sched.sv
// In-order scheduler from a request FIFO onto a banked memory with one read in flight.
// Optional per-bank write counters when BANK_STATS_EN is defined.
module mem_req_sched
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data
`ifdef BANK_STATS_EN
    ,
    output logic [3:0][7:0] bank_wr_cnt
`endif
);

    localparam int unsigned RW = 1 + AW + DW;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [RW-1:0] head;
    logic          head_we;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_wdata;
    logic          issue_wr;
    logic          issue_rd;

    assign head_we    = head[RW-1];
    assign head_addr  = head[DW +: AW];
    assign head_wdata = head[DW-1:0];

    assign req_ready = !full;
    assign push      = req_valid && !full;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .W     (RW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({req_we, req_addr, req_wdata}),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Issue decision, memory drive and next state
    always_comb begin
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = state;

        if (!empty) begin
            if (head_we) begin
                issue_wr = 1'b1;
            end else if (state == ST_RUN && (!rsp_valid || rsp_ready)) begin
                issue_rd = 1'b1;
            end
        end

        if (issue_wr) begin
            mem_wen   = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_wdata;
        end else if (issue_rd) begin
            mem_addr = head_addr;
        end

        pop       = issue_wr || issue_rd;
        count_nxt = count + CW'(push) - CW'(pop);

        if (issue_rd) begin
            state_nxt = ST_RD_WAIT;
        end else if (count_nxt == '0) begin
            state_nxt = ST_IDLE;
        end else begin
            state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response register: loads in the cycle after a read issue, held until accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else if (state == ST_RD_WAIT) begin
            rsp_valid <= 1'b1;
            rsp_data  <= mem_rdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef BANK_STATS_EN
    logic [1:0] wr_bank;

    assign wr_bank = mem_addr[AW-1 -: 2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_wr_cnt <= '0;
        end else if (mem_wen && bank_wr_cnt[wr_bank] != 8'hFF) begin
            bank_wr_cnt[wr_bank] <= bank_wr_cnt[wr_bank] + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// Directed plus random checks of mem_req_sched against a queue-based reference model.
module tb_mem_req_sched;
    import mem_pkg::*;

    localparam int unsigned AW    = AW_DEF;
    localparam int unsigned DW    = DW_DEF;
    localparam int unsigned DEPTH = DEPTH_DEF;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
`ifdef BANK_STATS_EN
    logic [3:0][7:0] bank_wr_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    mem_req_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data)
`ifdef BANK_STATS_EN
        ,
        .bank_wr_cnt (bank_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Banked memory: synchronous write, registered read data
    logic [DW-1:0] ram [2**AW];
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Reference model state
    req_t          q[$];
    logic [DW-1:0] m_mem [2**AW];
    logic          m_rd_wait = 1'b0;
    logic          m_rsp_valid = 1'b0;
    logic [DW-1:0] m_rsp_data = '0;
    logic [DW-1:0] m_pend = '0;
    int            m_bank [4];
    logic          last_accept = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_rd_wait   = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        for (int b = 0; b < 4; b++) m_bank[b] = 0;
    endtask

    // One clock: compare at the falling edge, then advance the model at the rising edge
    task automatic cycle();
        logic          e_ready, wr_iss, rd_iss;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        req_t          h;
        @(negedge clk);
        e_ready = (q.size() < DEPTH);
        wr_iss  = 1'b0;
        rd_iss  = 1'b0;
        h       = '0;
        if (q.size() > 0) begin
            h = q[0];
            if (h.we) wr_iss = 1'b1;
            else if (!m_rd_wait && (!m_rsp_valid || rsp_ready)) rd_iss = 1'b1;
        end
        e_addr  = (wr_iss || rd_iss) ? h.addr : '0;
        e_wdata = wr_iss ? h.wdata : '0;
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("mem_wen",   32'(mem_wen),   32'(wr_iss));
        chk("mem_addr",  32'(mem_addr),  32'(e_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        if (m_rsp_valid) chk("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
`ifdef BANK_STATS_EN
        for (int b = 0; b < 4; b++) chk($sformatf("bank_wr_cnt%0d", b), 32'(bank_wr_cnt[b]), 32'(m_bank[b]));
`endif
        @(posedge clk);
        last_accept = req_valid && e_ready;
        if (wr_iss) begin
            m_mem[h.addr] = h.wdata;
            if (m_bank[h.addr[AW-1 -: 2]] < 255) m_bank[h.addr[AW-1 -: 2]]++;
        end
        if (m_rd_wait) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = m_pend;
        end else if (m_rsp_valid && rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        if (rd_iss) m_pend = m_mem[h.addr];
        if (wr_iss || rd_iss) void'(q.pop_front());
        if (last_accept) q.push_back('{we: req_we, addr: req_addr, wdata: req_wdata});
        m_rd_wait = rd_iss;
        #1;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_mem_wen",   32'(mem_wen),   32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int budget = 40;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        last_accept = 1'b0;
        while (!last_accept && budget > 0) begin
            cycle();
            budget--;
        end
        chk("push_accepted", 32'(last_accept), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 60;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((q.size() > 0 || m_rd_wait || m_rsp_valid) && budget > 0) begin
            cycle();
            budget--;
        end
        chk("drain_done", 32'(q.size() == 0 && !m_rd_wait && !m_rsp_valid), 32'd1);
        cycle();
    endtask

    initial begin
        logic [AW-1:0] ra;
        for (int i = 0; i < 2**AW; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        model_clear();
        #2;
        do_reset();
        cycle();

        // Write then read of the same address
        rsp_ready = 1'b1;
        push_req(1'b1, 10'h2BD, 8'h23);
        push_req(1'b0, 10'h2BD, 8'h00);
        drain();
        chk("wr_rd_data", 32'(m_rsp_data), 32'h23);

        // Held response blocks the next read
        rsp_ready = 1'b0;
        push_req(1'b0, 10'h000, 8'h00);
        push_req(1'b0, 10'h0BD, 8'h00);
        repeat (3) cycle();
        drain();

        // Fill while a read sits behind a held response
        rsp_ready = 1'b0;
        push_req(1'b0, 10'h100, 8'h00);
        repeat (3) cycle();
        push_req(1'b0, 10'h200, 8'h00);
        for (int i = 0; i < 3; i++) push_req(1'b1, AW'(10'h300 + i), DW'(8'h40 + i));
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h303;
        req_wdata = 8'h43;
        repeat (3) cycle();
        chk("full_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        push_req(1'b1, 10'h303, 8'h43);
        push_req(1'b1, 10'h304, 8'h44);
        drain();

        // Reset while a read is in flight with entries queued
        rsp_ready = 1'b1;
        push_req(1'b0, 10'h2BD, 8'h00);
        push_req(1'b0, 10'h300, 8'h00);
        push_req(1'b0, 10'h301, 8'h00);
        push_req(1'b0, 10'h302, 8'h00);
        do_reset();
        repeat (4) cycle();

        // Interleaved writes and reads to one address
        push_req(1'b1, 10'h2BD, 8'hBF);
        push_req(1'b0, 10'h2BD, 8'h00);
        push_req(1'b1, 10'h2BD, 8'h00);
        push_req(1'b0, 10'h2BD, 8'h00);
        drain();

        // Random traffic over a small address set
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 10'h2BD;
                1: ra = 10'h000;
                2: ra = 10'h0BD;
                default: ra = AW'($urandom_range(0, 2**AW - 1));
            endcase
            req_valid = 1'(($urandom % 3) != 0);
            req_we    = 1'($urandom % 2);
            req_addr  = ra;
            req_wdata = DW'($urandom);
            rsp_ready = 1'(($urandom % 4) != 0);
            cycle();
        end
        drain();

`ifdef BANK_STATS_EN
        do_reset();
        for (int i = 0; i < 300; i++) push_req(1'b1, {2'b10, 8'($urandom)}, DW'($urandom));
        drain();
        chk("bank2_sat",  32'(bank_wr_cnt[2]), 32'd255);
        chk("bank0_zero", 32'(bank_wr_cnt[0]), 32'd0);
        chk("bank1_zero", 32'(bank_wr_cnt[1]), 32'd0);
        chk("bank3_zero", 32'(bank_wr_cnt[3]), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
